// File: rtl/edge_irq_detect_pkg.sv
// Shared definitions for the multi-channel edge interrupt detector:
// per-channel edge-mode encoding and the mode qualification helper.
package edge_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_POS  = 2'b01,
        EDGE_NEG  = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Decide whether a level transition counts as an event under the given mode.
    function automatic logic edge_qualify(edge_mode_e mode, logic rise, logic fall);
        logic hit;
        case (mode)
            EDGE_POS:  hit = rise;
            EDGE_NEG:  hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_irq_detect_if.sv
// Bundle of the detector's control inputs and status outputs. The master side
// (register block / testbench) drives pins, modes, filter length and clears;
// the slave side (the detector) returns level, pulses, sticky flags and irq.
interface edge_irq_detect_if #(
    parameter int N  = 4,
    parameter int FW = 4
);
    import edge_pkg::*;

    logic [N-1:0]        din;
    logic [MODE_W*N-1:0] mode;
    logic [FW-1:0]       filt_len;
    logic [N-1:0]        clr;
    logic [N-1:0]        level;
    logic [N-1:0]        edge_pulse;
    logic [N-1:0]        pending;
    logic [N-1:0]        overrun;
    logic                irq;

    modport master (
        output din, mode, filt_len, clr,
        input  level, edge_pulse, pending, overrun, irq
    );

    modport slave (
        input  din, mode, filt_len, clr,
        output level, edge_pulse, pending, overrun, irq
    );

endinterface

// File: rtl/edge_irq_detect_filter_ch.sv
// One channel: synchroniser, debounce counter, filtered level register and
// mode-qualified edge event. evt_o is the combinational event that the top
// level uses to set the sticky flags on the same clock edge that pulse_o rises.
module edge_filter_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_i,
    input  edge_mode_e    mode_i,
    input  logic [FW-1:0] filt_len_i,
    output logic          level_o,
    output logic          evt_o,
    output logic          pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q;
    logic                   s;
    logic                   rise, fall;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain: stage 0 samples the raw pin.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    // Debounce: level follows s only after s has disagreed for filt_len+1 edges.
    // NOTE: next-state defaults come first so no path leaves cnt_d/level_d unassigned (no latch).
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q < filt_len_i) begin
            cnt_d = cnt_q + FW'(1);
        end else begin
            // >= rather than == so lowering filt_len mid-count still commits.
            level_d = s;
            cnt_d   = '0;
        end
    end

    assign rise  = level_d & ~level_q;
    assign fall  = ~level_d & level_q;
    assign evt_o = edge_qualify(mode_i, rise, fall);

    // Filter state and registered one-cycle pulse aligned with the new level.
    // NOTE: reset is synchronous, so it only acts on a clock edge while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= evt_o;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/edge_irq_detect.sv
// Multi-channel edge interrupt detector. Each channel is filtered and
// qualified independently; this level keeps the sticky pending/overrun flags
// and ORs pending into a single interrupt.
module edge_irq_detect
    import edge_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FW          = 4
) (
    input  logic              clk,
    input  logic              rst,
    edge_irq_detect_if.slave  bus
);

    logic [N-1:0] level_w;
    logic [N-1:0] evt_w;
    logic [N-1:0] pulse_w;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] overrun_q, overrun_d;

    for (genvar gi = 0; gi < N; gi++) begin : gen_ch
        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FW          (FW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din_i      (bus.din[gi]),
            .mode_i     (edge_mode_e'(bus.mode[MODE_W*gi +: MODE_W])),
            .filt_len_i (bus.filt_len),
            .level_o    (level_w[gi]),
            .evt_o      (evt_w[gi]),
            .pulse_o    (pulse_w[gi])
        );
    end

    // Sticky flags: a new event beats a simultaneous clear so no edge is lost;
    // overrun only records events that arrive while pending is held uncleared.
    always_comb begin
        pending_d = (pending_q & ~bus.clr) | evt_w;
        overrun_d = (overrun_q & ~bus.clr) | (evt_w & pending_q & ~bus.clr);
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.level      = level_w;
    assign bus.edge_pulse = pulse_w;
    assign bus.pending    = pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.irq        = |pending_q;

endmodule
